fb_write_unit: RTL and testbench

Framebuffer write stage: consumes depth-passed fragments from `depth_buffer` and commits RGB565 pixels to the framebuffer BRAM via its read and write ports. Performs optional source-alpha blending through a read-modify-write pipeline with same-address hazard stalls. Also runs a full-screen color clear. Sits between `depth_buffer` and `framebuffer`.

---
 rtl/fb_write_unit_if.sv | 51 +++++
 rtl/fb_write_unit.sv | 167 ++++++++++++++++
 tb/tb_fb_write_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_unit_if.sv
// Shared pixel types and the fragment-stream / framebuffer-port bundle for fb_write_unit.
package fb_types_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        valid;
  } fragment_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic [7:0] alpha_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } clear_state_e;
endpackage

// Handshake: a fragment transfers on a rising clk edge where frag_in_valid and
// frag_in_ready are both high; frag_in_ready never depends on frag_in_valid.
interface fb_write_unit_if #(
  parameter int ADDR_BITS = 19
);
  import fb_types_pkg::*;

  logic                 frag_in_valid;
  logic                 frag_in_ready;
  fragment_t            frag_in;
  rgb565_t              color_in;
  alpha_t               tex_alpha_in;
  logic [ADDR_BITS-1:0] fb_rd_addr;
  logic [15:0]          fb_rd_data;
  logic                 fb_wr_en;
  logic [ADDR_BITS-1:0] fb_wr_addr;
  logic [15:0]          fb_wr_data;

  modport master (
    output frag_in_valid, frag_in, color_in, tex_alpha_in, fb_rd_data,
    input  frag_in_ready, fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input  frag_in_valid, frag_in, color_in, tex_alpha_in, fb_rd_data,
    output frag_in_ready, fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/fb_write_unit.sv
// Framebuffer write stage: optional source-alpha blend via read-modify-write on a
// read-first BRAM, same-address hazard stalls, and a full-screen colour clear.
module fb_write_unit
  import fb_types_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          blend_enable,
  input  logic          color_clear,
  input  logic [15:0]   clear_color,
  output logic          color_clearing,
  output logic [31:0]   pixels_written,
  output clear_state_e  dbg_state_o,
  fb_write_unit_if.slave fb
);
  localparam int NPIX      = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_BITS = $clog2(NPIX);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);

  clear_state_e         state_q, state_d;
  logic [ADDR_BITS-1:0] clear_addr_q, clear_addr_d;

  logic                 p1_live_q;
  logic [ADDR_BITS-1:0] p1_addr_q;
  rgb565_t              p1_color_q;
  alpha_t               p1_alpha_q;
  logic                 p1_blend_q;

  logic                 wr_en_q, wr_en_d;
  logic                 wr_live_q, wr_live_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic [31:0]          count_q;

  logic [31:0]          x_w, y_w, lin_addr_w;
  logic [ADDR_BITS-1:0] in_addr_w;
  logic                 in_bounds_w, hazard_w, ready_w, accept_w;

  assign x_w         = 32'(fb.frag_in.x);
  assign y_w         = 32'(fb.frag_in.y);
  assign lin_addr_w  = y_w * 32'(FB_WIDTH) + x_w;
  assign in_addr_w   = lin_addr_w[ADDR_BITS-1:0];
  assign in_bounds_w = (x_w < 32'(FB_WIDTH)) && (y_w < 32'(FB_HEIGHT));

  // A blended read must not be issued until any in-flight write to the same pixel
  // has committed, otherwise the read-first BRAM hands back stale data.
  assign hazard_w = blend_enable &&
                    ((p1_live_q && (p1_addr_q == in_addr_w)) ||
                     (wr_live_q && (wr_addr_q == in_addr_w)));
  assign ready_w  = rst_n && (state_q == ST_IDLE) && !color_clear && !hazard_w;
  assign accept_w = fb.frag_in_valid && ready_w;

  assign fb.frag_in_ready = ready_w;
  assign fb.fb_rd_addr    = in_addr_w;

  // P1: fragment waiting for its destination pixel to come back from the BRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_live_q  <= 1'b0;
      p1_addr_q  <= '0;
      p1_color_q <= '0;
      p1_alpha_q <= '0;
      p1_blend_q <= 1'b0;
    end else begin
      p1_live_q <= accept_w && fb.frag_in.valid && in_bounds_w;
      if (accept_w) begin
        p1_addr_q  <= in_addr_w;
        p1_color_q <= fb.color_in;
        p1_alpha_q <= fb.tex_alpha_in;
        p1_blend_q <= blend_enable;
      end
    end
  end

  function automatic logic [5:0] mix_ch(input logic [5:0] s, input logic [5:0] d,
                                        input logic [8:0] a);
    logic [15:0] acc;
    acc = 16'(s) * 16'(a) + 16'(d) * (16'd256 - 16'(a));
    return acc[13:8];
  endfunction

  logic [8:0] a_w;
  rgb565_t    dst_w, mix_w, px_w;

  // Folding the top alpha bit in maps 0..255 onto 0..256 so 255 is exactly opaque.
  assign a_w     = {1'b0, p1_alpha_q} + {8'd0, p1_alpha_q[7]};
  assign dst_w   = fb.fb_rd_data;
  assign mix_w.r = 5'(mix_ch({1'b0, p1_color_q.r}, {1'b0, dst_w.r}, a_w));
  assign mix_w.g = mix_ch(p1_color_q.g, dst_w.g, a_w);
  assign mix_w.b = 5'(mix_ch({1'b0, p1_color_q.b}, {1'b0, dst_w.b}, a_w));
  assign px_w    = p1_blend_q ? mix_w : p1_color_q;

  // Write register: clear writes take the port in CLEAR, where P1 is always empty.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_live_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == ST_CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clear_addr_q;
      wr_data_d = clear_color;
    end else if (p1_live_q) begin
      wr_en_d   = 1'b1;
      wr_live_d = 1'b1;
      wr_addr_d = p1_addr_q;
      wr_data_d = px_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_live_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_live_q <= wr_live_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_q + 32'(wr_live_d);
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (color_clear) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!p1_live_q && !wr_live_q) begin
          state_d      = ST_CLEAR;
          clear_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clear_addr_d = clear_addr_q + ADDR_BITS'(1);
        if (clear_addr_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  assign color_clearing = (state_q != ST_IDLE);
  assign pixels_written = count_q;
  assign dbg_state_o    = state_q;
  assign fb.fb_wr_en    = wr_en_q;
  assign fb.fb_wr_addr  = wr_addr_q;
  assign fb.fb_wr_data  = wr_data_q;
endmodule

// File: tb/tb_fb_write_unit.sv
// Directed bench for fb_write_unit: a 640x480 instance for pixel/blend/hazard work and
// a 4x2 instance for clear sequencing, each with a read-first BRAM model.
module tb_fb_write_unit;
  import fb_types_pkg::*;

  localparam int AW_A = 19;
  localparam int AW_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_write_unit_if #(.ADDR_BITS(AW_A)) if_a ();
  fb_write_unit_if #(.ADDR_BITS(AW_B)) if_b ();

  logic         blend_a, clear_a, clearing_a;
  logic [15:0]  ccol_a;
  logic [31:0]  cnt_a;
  clear_state_e st_a;
  logic         blend_b, clear_b, clearing_b;
  logic [15:0]  ccol_b;
  logic [31:0]  cnt_b;
  clear_state_e st_b;

  fb_write_unit #(.FB_WIDTH(640), .FB_HEIGHT(480)) dut_a (
    .clk(clk), .rst_n(rst_n), .blend_enable(blend_a), .color_clear(clear_a),
    .clear_color(ccol_a), .color_clearing(clearing_a), .pixels_written(cnt_a),
    .dbg_state_o(st_a), .fb(if_a.slave)
  );

  fb_write_unit #(.FB_WIDTH(4), .FB_HEIGHT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .blend_enable(blend_b), .color_clear(clear_b),
    .clear_color(ccol_b), .color_clearing(clearing_b), .pixels_written(cnt_b),
    .dbg_state_o(st_b), .fb(if_b.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read-first BRAM models with one-cycle read latency.
  logic [15:0]     mem_a [0:(1<<AW_A)-1];
  logic [15:0]     mem_b [0:(1<<AW_B)-1];
  logic            pre_en = 1'b0;
  logic [AW_A-1:0] pre_addr = '0;
  logic [15:0]     pre_data = '0;

  always @(posedge clk) begin
    if_a.fb_rd_data <= mem_a[if_a.fb_rd_addr];
    if (pre_en) mem_a[pre_addr] <= pre_data;
    else if (if_a.fb_wr_en) mem_a[if_a.fb_wr_addr] <= if_a.fb_wr_data;
  end

  always @(posedge clk) begin
    if_b.fb_rd_data <= mem_b[if_b.fb_rd_addr];
    if (if_b.fb_wr_en) mem_b[if_b.fb_wr_addr] <= if_b.fb_wr_data;
  end

  // Scoreboards: every write must match the head of the expected queue, in order.
  logic [AW_A+15:0] exp_a_q[$];
  logic [AW_B+15:0] exp_b_q[$];
  logic             mon_b_en = 1'b0;
  int               exp_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && if_a.fb_wr_en) begin
      logic [AW_A+15:0] e;
      e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : '1;
      check_val("a_wr", {if_a.fb_wr_addr, if_a.fb_wr_data}, e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_b_en && if_b.fb_wr_en) begin
      logic [AW_B+15:0] e;
      e = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : '1;
      check_val("b_wr", {if_b.fb_wr_addr, if_b.fb_wr_data}, e);
    end
  end

  task automatic push_a(input int x, input int y, input logic [15:0] d);
    exp_a_q.push_back({AW_A'(y * 640 + x), d});
    exp_cnt++;
  endtask

  task automatic preload_a(input int x, input int y, input logic [15:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = AW_A'(y * 640 + x); pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic send_a(input int x, input int y, input logic fv, input logic [15:0] col,
                        input logic [7:0] al, input logic bl, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    @(negedge clk);
    if_a.frag_in_valid = 1'b1;
    if_a.frag_in.x = 16'(x); if_a.frag_in.y = 16'(y); if_a.frag_in.valid = fv;
    if_a.color_in = col; if_a.tex_alpha_in = al; blend_a = bl;
    for (int g = 0; g < 20 && !acc; g++) begin
      #1;
      if (if_a.frag_in_ready) acc = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (acc) @(posedge clk);
    else check_val("a_accept_timeout", 64'(stalls), 64'd0);
  endtask

  task automatic idle_a();
    @(negedge clk);
    if_a.frag_in_valid = 1'b0;
  endtask

  task automatic send_b(input int x, input int y, input logic [15:0] col);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    if_b.frag_in_valid = 1'b1;
    if_b.frag_in.x = 16'(x); if_b.frag_in.y = 16'(y); if_b.frag_in.valid = 1'b1;
    if_b.color_in = col; if_b.tex_alpha_in = 8'h00; blend_b = 1'b0;
    for (int g = 0; g < 20 && !acc; g++) begin
      #1;
      if (if_b.frag_in_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (acc) @(posedge clk);
    else check_val("b_accept_timeout", 64'(acc), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int s, s2;
    logic done;
    if_a.frag_in_valid = 1'b0; if_a.frag_in = '0; if_a.color_in = '0; if_a.tex_alpha_in = '0;
    if_b.frag_in_valid = 1'b0; if_b.frag_in = '0; if_b.color_in = '0; if_b.tex_alpha_in = '0;
    blend_a = 1'b0; clear_a = 1'b0; ccol_a = '0;
    blend_b = 1'b0; clear_b = 1'b0; ccol_b = '0;

    // Reset behaviour.
    repeat (3) @(negedge clk);
    check_val("rst_ready_a", if_a.frag_in_ready, 0);
    check_val("rst_ready_b", if_b.frag_in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready", if_a.frag_in_ready, 1);
    check_val("rel_wr_en", if_a.fb_wr_en, 0);
    check_val("rel_wr_addr", if_a.fb_wr_addr, 0);
    check_val("rel_wr_data", if_a.fb_wr_data, 0);
    check_val("rel_count", cnt_a, 0);
    check_val("rel_clearing", clearing_a, 0);

    // First fragment: write appears two edges after accept at address 2*640+3.
    push_a(3, 2, 16'hF800);
    @(negedge clk);
    if_a.frag_in_valid = 1'b1; if_a.frag_in.x = 16'd3; if_a.frag_in.y = 16'd2;
    if_a.frag_in.valid = 1'b1; if_a.color_in = 16'hF800; blend_a = 1'b0;
    #1;
    check_val("t1_ready", if_a.frag_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if_a.frag_in_valid = 1'b0;
    check_val("t1_wr_early", if_a.fb_wr_en, 0);
    @(negedge clk);
    check_val("t1_wr_en", if_a.fb_wr_en, 1);
    check_val("t1_wr_addr", if_a.fb_wr_addr, 1283);
    check_val("t1_wr_data", if_a.fb_wr_data, 16'hF800);
    check_val("t1_count", cnt_a, 1);

    // Blend vectors (A = alpha + alpha[7]):
    // 0x80 over 0x001F: R=(31*129)>>8=15, B=(31*127)>>8=15 -> 0x780F.
    preload_a(5, 5, 16'h001F);
    preload_a(6, 5, 16'h001F);
    preload_a(7, 5, 16'h001F);
    preload_a(8, 5, 16'h1234);
    preload_a(10, 10, 16'h0000);
    push_a(5, 5, 16'h780F);
    push_a(6, 5, 16'hF800);
    push_a(7, 5, 16'h001F);
    push_a(8, 5, 16'h07E0);
    send_a(5, 5, 1'b1, 16'hF800, 8'h80, 1'b1, s);
    check_val("blend_mid_stall", s, 0);
    send_a(6, 5, 1'b1, 16'hF800, 8'hFF, 1'b1, s);
    check_val("blend_opaque_stall", s, 0);
    send_a(7, 5, 1'b1, 16'hF800, 8'h00, 1'b1, s);
    check_val("blend_clear_stall", s, 0);
    send_a(8, 5, 1'b1, 16'h07E0, 8'h00, 1'b0, s);
    check_val("overwrite_stall", s, 0);
    idle_a();
    repeat (3) @(negedge clk);

    // Hazard: first 0xFFFF@0x80 over 0 -> 0x7BEF; second over 0x7BEF -> R23 G47 B23 = 0xBDF7.
    push_a(10, 10, 16'h7BEF);
    push_a(10, 10, 16'hBDF7);
    send_a(10, 10, 1'b1, 16'hFFFF, 8'h80, 1'b1, s);
    check_val("haz_first_stall", s, 0);
    send_a(10, 10, 1'b1, 16'hFFFF, 8'h80, 1'b1, s2);
    check_val("haz_second_stall", s2, 2);

    // Overwrites to one address never stall.
    push_a(20, 20, 16'h1111);
    push_a(20, 20, 16'h2222);
    send_a(20, 20, 1'b1, 16'h1111, 8'h00, 1'b0, s);
    check_val("nb_first_stall", s, 0);
    send_a(20, 20, 1'b1, 16'h2222, 8'h00, 1'b0, s);
    check_val("nb_second_stall", s, 0);

    // Drops: accepted without stalling, never written or counted.
    send_a(640, 0, 1'b1, 16'hABCD, 8'h00, 1'b0, s);
    check_val("drop_x_stall", s, 0);
    send_a(1, 1, 1'b0, 16'hABCD, 8'h00, 1'b0, s);
    check_val("drop_inv_stall", s, 0);
    send_a(0, 480, 1'b1, 16'hABCD, 8'h00, 1'b0, s);
    check_val("drop_y_stall", s, 0);
    idle_a();
    repeat (4) @(negedge clk);
    check_val("a_count", cnt_a, 64'(exp_cnt));
    check_val("a_q_empty", exp_a_q.size(), 0);

    // Clear on the 4x2 instance with two fragments in flight.
    mon_b_en = 1'b1;
    exp_b_q.push_back({3'd1, 16'hAAAA});
    exp_b_q.push_back({3'd6, 16'h5555});
    for (int i = 0; i < 8; i++) exp_b_q.push_back({3'(i), 16'h1234});
    send_b(1, 0, 16'hAAAA);
    send_b(2, 1, 16'h5555);
    @(negedge clk);
    if_b.frag_in.x = 16'd3; if_b.frag_in.y = 16'd1; if_b.color_in = 16'hEEEE;
    clear_b = 1'b1; ccol_b = 16'h1234;
    #1;
    check_val("clr_wins_ready", if_b.frag_in_ready, 0);
    @(negedge clk);
    clear_b = 1'b0; if_b.frag_in_valid = 1'b0;
    check_val("clr_clearing", clearing_b, 1);
    check_val("clr_state_drain", st_b, ST_DRAIN);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (!clearing_b) done = 1'b1;
      else begin
        check_val("clr_ready_low", if_b.frag_in_ready, 0);
        clear_b = (i == 5);
        @(negedge clk);
      end
    end
    clear_b = 1'b0;
    if (!done) check_val("clr_timeout", clearing_b, 0);
    repeat (3) @(negedge clk);
    check_val("clr_q_empty", exp_b_q.size(), 0);
    check_val("clr_count", cnt_b, 2);
    check_val("clr_state_idle", st_b, ST_IDLE);
    check_val("clr_ready_after", if_b.frag_in_ready, 1);
    repeat (12) @(negedge clk);
    check_val("clr_no_restart", clearing_b, 0);

    // Asynchronous reset in the middle of a clear.
    mon_b_en = 1'b0;
    @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    clear_b = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (if_b.fb_wr_en) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check_val("abort_no_clear", if_b.fb_wr_en, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_wr_en", if_b.fb_wr_en, 0);
    check_val("abort_clearing", clearing_b, 0);
    check_val("abort_ready", if_b.frag_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("abort_state", st_b, ST_IDLE);
    check_val("abort_ready_rel", if_b.frag_in_ready, 1);
    check_val("abort_count", cnt_b, 0);
    repeat (10) @(negedge clk);
    check_val("abort_stays_idle", clearing_b, 0);
    check_val("abort_no_write", if_b.fb_wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
